alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning clock edges from the ALU sampling its operands to its outputs being stable and capturable (range 1-4).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock shared with the ALU.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid in 1 / req_ready out 1 / req_a in 32 / req_b in 32 / req_op in 3: operation request channel.
REQ-005 alu_a out 32 / alu_b out 32 / alu_ctrl out 3: registered operand and control drive to the ALU.
REQ-006 alu_out in 32 / alu_upper in 32 / alu_zero, alu_carry, alu_ovf, alu_neg, alu_divz in 1 each: ALU result and flag inputs.
REQ-007 rsp_valid out 1 / rsp_ready in 1 / rsp_result out 32 / rsp_upper out 32 / rsp_flags out 5 {divz,neg,ovf,carry,zero} / rsp_op out 3 / rsp_err out 1: response channel.
REQ-008 op_count out 16: count of completed responses, saturating.

Function
REQ-009 Op encoding SHALL be 000 add, 001 sub, 010 and, 011 or, 100 slt, 101 mul, 110 div, 111 illegal.
REQ-010 FSM states SHALL be IDLE, DRIVE, WAIT, RESP.
REQ-011 IDLE: req_ready=1; on req_valid&req_ready, latch a/b/op, go to DRIVE; if op=111, go directly to RESP with rsp_err=1, rsp_result=0, rsp_upper=0, rsp_flags=0, and no ALU drive change.
REQ-012 DRIVE: alu_a/alu_b/alu_ctrl SHALL hold the latched request for the entire state; the ALU samples at the DRIVE-exit edge; go to WAIT.
REQ-013 WAIT: SHALL last exactly ALU_LAT cycles via a down-counter; at the final WAIT edge, capture ALU inputs into rsp_* and go to RESP.
REQ-014 alu_a/alu_b/alu_ctrl SHALL be held stable from DRIVE entry through RESP exit.
REQ-015 RESP: rsp_valid=1; rsp_* stable while rsp_valid&!rsp_ready; on rsp_ready, go to IDLE.
REQ-016 req_ready SHALL be 1 only in IDLE; exactly one operation is in flight.
REQ-017 Flag masking: carry and ovf SHALL be passed only for add/sub; ovf SHALL also be passed for mul; divz SHALL be passed only for div; all masked flags SHALL be 0 in rsp_flags.
REQ-018 zero and neg SHALL be passed for all legal ops; neg SHALL equal alu_out[31] when the ALU neg input is unasserted.
REQ-019 rsp_upper SHALL equal alu_upper for mul and 0 for all other ops.
REQ-020 rsp_result SHALL equal alu_out; for div with divz, rsp_result SHALL be forced to 32'hFFFFFFFF.
REQ-021 rsp_op SHALL echo the latched request op; rsp_err SHALL be 0 for legal ops.
REQ-022 op_count SHALL increment on each rsp_valid&rsp_ready handshake, including errors, and saturate at 16'hFFFF.
REQ-023 A new request SHALL NOT be accepted in the same cycle as a response handshake; IDLE is always entered first.

Reset
REQ-024 On rst=1, asynchronously: state=IDLE, req_ready=1, rsp_valid=0, rsp_err=0, alu_a=alu_b=0, alu_ctrl=000, and all rsp_* and op_count=0.
REQ-025 Reset asserted in DRIVE, WAIT, or RESP SHALL abandon the operation with no response; the first post-reset request SHALL be processed normally.

Verification
REQ-026 add 7FFFFFFF+1, ALU_LAT=1 -> rsp after 3 edges; result 80000000; flags ovf=1, neg=1, carry=0, zero=0; upper=0.
REQ-027 mul 00010000*00010000 -> result 0, upper 1, zero=1, ovf=1; a following and with ALU ovf still high -> rsp ovf=0.
REQ-028 div 5/0 -> result FFFFFFFF, divz=1; a following add 1+1 -> result 2, divz=0.
REQ-029 op=111 -> rsp_err=1 one edge after acceptance; alu_ctrl unchanged; op_count increments.
REQ-030 rsp_ready held 0 for 5 cycles -> rsp_* stable, req_ready=0; release -> IDLE next edge, then the next request is accepted.
REQ-031 rst pulse mid-WAIT -> no rsp_valid; outputs at reset values; the next sub 3-5 -> result FFFFFFFE, carry=1, neg=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Sequences one operation at a time through an external multi-cycle ALU.
//   A request is latched in IDLE, the operands/control are driven to the ALU
//   and held steady, the ALU result is captured ALU_LAT edges after the ALU
//   samples, and the masked result is offered on the response channel until
//   it is accepted.
//
// Ports
//   clk, rst                 clock shared with the ALU; async active-high reset
//   req_valid/req_ready      request handshake; req_a, req_b operands, req_op opcode
//   alu_a, alu_b, alu_ctrl   registered drive to the ALU
//   alu_out, alu_upper       ALU result (low word, upper word)
//   alu_zero..alu_divz       ALU status flags
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_upper    captured result words
//   rsp_flags                {divz, neg, ovf, carry, zero}, masked per opcode
//   rsp_op, rsp_err          echoed opcode; error for the illegal opcode
//   op_count                 saturating count of completed responses
module alu_sequencer #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [2:0]  req_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_out,
    input  logic [31:0] alu_upper,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_ovf,
    input  logic        alu_neg,
    input  logic        alu_divz,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [31:0] rsp_upper,
    output logic [4:0]  rsp_flags,
    output logic [2:0]  rsp_op,
    output logic        rsp_err,
    output logic [15:0] op_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam logic [2:0] OP_DIV = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    // WAIT counts down from ALU_LAT-1 to 0; the capture happens on the 0 cycle.
    localparam logic [1:0] WAIT_INIT = 2'(ALU_LAT - 1);

    logic [1:0]  state_q,  state_d;
    logic [1:0]  cnt_q,    cnt_d;
    logic [31:0] alu_a_q,  alu_a_d;
    logic [31:0] alu_b_q,  alu_b_d;
    logic [2:0]  ctrl_q,   ctrl_d;
    logic [2:0]  op_q,     op_d;
    logic [31:0] result_q, result_d;
    logic [31:0] upper_q,  upper_d;
    logic [4:0]  flags_q,  flags_d;
    logic        err_q,    err_d;
    logic [15:0] count_q,  count_d;

    logic is_addsub;
    logic is_mul;
    logic is_div;

    assign is_addsub = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign is_mul    = (op_q == OP_MUL);
    assign is_div    = (op_q == OP_DIV);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        ctrl_d   = ctrl_q;
        op_d     = op_q;
        result_d = result_q;
        upper_d  = upper_q;
        flags_d  = flags_q;
        err_d    = err_q;
        count_d  = count_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d = req_op;
                    if (req_op == OP_ILL) begin
                        // Illegal op never touches the ALU drive.
                        result_d = '0;
                        upper_d  = '0;
                        flags_d  = '0;
                        err_d    = 1'b1;
                        state_d  = RESP;
                    end else begin
                        alu_a_d = req_a;
                        alu_b_d = req_b;
                        ctrl_d  = req_op;
                        state_d = DRIVE;
                    end
                end
            end
            DRIVE: begin
                cnt_d   = WAIT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 2'd0) begin
                    result_d = (is_div && alu_divz) ? '1 : alu_out;
                    upper_d  = is_mul ? alu_upper : '0;
                    // neg falls back to the result sign bit when the ALU does not flag it.
                    flags_d  = {alu_divz & is_div,
                                alu_neg | alu_out[31],
                                alu_ovf & (is_addsub | is_mul),
                                alu_carry & is_addsub,
                                alu_zero};
                    err_d    = 1'b0;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            ctrl_q   <= '0;
            op_q     <= '0;
            result_q <= '0;
            upper_q  <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            ctrl_q   <= ctrl_d;
            op_q     <= op_d;
            result_q <= result_d;
            upper_q  <= upper_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
            count_q  <= count_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_ctrl   = ctrl_q;
    assign rsp_result = result_q;
    assign rsp_upper  = upper_q;
    assign rsp_flags  = flags_q;
    assign rsp_op     = op_q;
    assign rsp_err    = err_q;
    assign op_count   = count_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer
//   Directed bench for alu_sequencer. The ALU inputs carry junk values except
//   during the single cycle before the expected capture edge, so a capture on
//   the wrong edge shows up as a wrong response.
module tb_alu_sequencer;

    localparam int unsigned LAT = 1;

    localparam logic [2:0] ADD = 3'b000;
    localparam logic [2:0] SUB = 3'b001;
    localparam logic [2:0] AND = 3'b010;
    localparam logic [2:0] OR  = 3'b011;
    localparam logic [2:0] SLT = 3'b100;
    localparam logic [2:0] MUL = 3'b101;
    localparam logic [2:0] DIV = 3'b110;
    localparam logic [2:0] ILL = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [2:0]  req_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_out;
    logic [31:0] alu_upper;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_ovf;
    logic        alu_neg;
    logic        alu_divz;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [31:0] rsp_upper;
    logic [4:0]  rsp_flags;
    logic [2:0]  rsp_op;
    logic        rsp_err;
    logic [15:0] op_count;

    int n_vec  = 0;
    int n_miss = 0;

    logic [15:0] exp_cnt;
    logic [31:0] last_a;
    logic [31:0] last_b;
    logic [2:0]  last_ctrl;

    alu_sequencer #(.ALU_LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_ctrl  (alu_ctrl),
        .alu_out   (alu_out),
        .alu_upper (alu_upper),
        .alu_zero  (alu_zero),
        .alu_carry (alu_carry),
        .alu_ovf   (alu_ovf),
        .alu_neg   (alu_neg),
        .alu_divz  (alu_divz),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_result(rsp_result),
        .rsp_upper (rsp_upper),
        .rsp_flags (rsp_flags),
        .rsp_op    (rsp_op),
        .rsp_err   (rsp_err),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic alu_junk();
        alu_out   = 32'hA5A5_5A5A;
        alu_upper = 32'h1234_5678;
        {alu_divz, alu_neg, alu_ovf, alu_carry, alu_zero} = 5'b11111;
    endtask

    // afl / efl are {divz, neg, ovf, carry, zero}. Called and returns at a negedge in IDLE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic [31:0] aout, input logic [31:0] aup, input logic [4:0] afl,
                          input logic [31:0] eres, input logic [31:0] eup, input logic [4:0] efl,
                          input int hold);
        chk("req_ready_idle", 64'(req_ready), 64'(1'b1));
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_op    = op;
        @(negedge clk);
        req_valid = 1'b0;
        if (op != ILL) begin
            chk("drive_a", 64'(alu_a), 64'(a));
            chk("drive_b", 64'(alu_b), 64'(b));
            chk("drive_ctrl", 64'(alu_ctrl), 64'(op));
            last_a    = a;
            last_b    = b;
            last_ctrl = op;
            for (int i = 0; i < int'(LAT); i++) begin
                chk("busy_no_rsp", 64'(rsp_valid), 64'(1'b0));
                chk("busy_not_ready", 64'(req_ready), 64'(1'b0));
                @(negedge clk);
            end
            alu_out   = aout;
            alu_upper = aup;
            {alu_divz, alu_neg, alu_ovf, alu_carry, alu_zero} = afl;
            chk("wait_hold_ctrl", 64'(alu_ctrl), 64'(op));
            @(negedge clk);
            alu_junk();
        end else begin
            chk("ill_ctrl_kept", 64'(alu_ctrl), 64'(last_ctrl));
            chk("ill_a_kept", 64'(alu_a), 64'(last_a));
        end
        chk("rsp_valid", 64'(rsp_valid), 64'(1'b1));
        chk("rsp_result", 64'(rsp_result), 64'(eres));
        chk("rsp_upper", 64'(rsp_upper), 64'(eup));
        chk("rsp_flags", 64'(rsp_flags), 64'(efl));
        chk("rsp_op", 64'(rsp_op), 64'(op));
        chk("rsp_err", 64'(rsp_err), 64'(op == ILL));

        // A competing request stays up through the stall and the handshake edge.
        req_valid = 1'b1;
        req_a     = 32'hBAD0_BAD0;
        req_b     = 32'h0000_0BAD;
        req_op    = ADD;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(rsp_valid), 64'(1'b1));
            chk("stall_result", 64'(rsp_result), 64'(eres));
            chk("stall_flags", 64'(rsp_flags), 64'(efl));
            chk("stall_not_ready", 64'(req_ready), 64'(1'b0));
            chk("stall_hold_a", 64'(alu_a), 64'(last_a));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        chk("hs_rsp_dropped", 64'(rsp_valid), 64'(1'b0));
        chk("hs_back_idle", 64'(req_ready), 64'(1'b1));
        chk("hs_no_accept_a", 64'(alu_a), 64'(last_a));
        chk("hs_no_accept_ctrl", 64'(alu_ctrl), 64'(last_ctrl));
        chk("op_count", 64'(op_count), 64'(exp_cnt));
        req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        alu_junk();
        exp_cnt   = '0;
        last_a    = '0;
        last_b    = '0;
        last_ctrl = '0;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'(1'b1));
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("rst_rsp_err", 64'(rsp_err), 64'(1'b0));
        chk("rst_alu_a", 64'(alu_a), 64'(32'h0));
        chk("rst_alu_b", 64'(alu_b), 64'(32'h0));
        chk("rst_alu_ctrl", 64'(alu_ctrl), 64'(3'b000));
        chk("rst_rsp_result", 64'(rsp_result), 64'(32'h0));
        chk("rst_rsp_flags", 64'(rsp_flags), 64'(5'b0));
        chk("rst_op_count", 64'(op_count), 64'(16'h0));
        rst = 1'b0;
        @(negedge clk);

        // add overflow: ovf, neg; divz masked, upper zeroed
        run_op(32'h7FFF_FFFF, 32'h1, ADD, 32'h8000_0000, 32'h0000_BEEF, 5'b11100,
               32'h8000_0000, 32'h0, 5'b01100, 0);
        // mul: upper passed, ovf kept, carry and divz masked
        run_op(32'h0001_0000, 32'h0001_0000, MUL, 32'h0, 32'h1, 5'b10111,
               32'h0, 32'h1, 5'b00101, 0);
        // and with ovf/carry high from ALU: masked; neg from result bit 31
        run_op(32'hF0F0_F0F0, 32'hFF00_FF00, AND, 32'hF000_F000, 32'h77, 5'b00110,
               32'hF000_F000, 32'h0, 5'b01000, 0);
        // div by zero: forced all-ones result, divz kept
        run_op(32'h5, 32'h0, DIV, 32'h0, 32'h5, 5'b11110,
               32'hFFFF_FFFF, 32'h0, 5'b11000, 0);
        // add 1+1 after div: divz masked
        run_op(32'h1, 32'h1, ADD, 32'h2, 32'h0, 5'b10000,
               32'h2, 32'h0, 5'b00000, 0);
        // illegal opcode
        run_op(32'hDEAD, 32'hBEEF, ILL, 32'h0, 32'h0, 5'b0,
               32'h0, 32'h0, 5'b00000, 0);
        // sub with a 5-cycle response stall
        run_op(32'd10, 32'd3, SUB, 32'd7, 32'h9, 5'b00000,
               32'd7, 32'h0, 5'b00000, 5);
        // slt: carry/ovf masked
        run_op(32'hFFFF_FFFF, 32'h1, SLT, 32'h1, 32'h3, 5'b00110,
               32'h1, 32'h0, 5'b00000, 0);
        // or to zero
        run_op(32'h0, 32'h0, OR, 32'h0, 32'h0, 5'b00001,
               32'h0, 32'h0, 5'b00001, 0);

        // reset pulse while the ALU is being waited on
        req_valid = 1'b1;
        req_a     = 32'h1111;
        req_b     = 32'h2222;
        req_op    = ADD;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'(1'b0));
        chk("midrst_req_ready", 64'(req_ready), 64'(1'b1));
        chk("midrst_alu_a", 64'(alu_a), 64'(32'h0));
        chk("midrst_alu_ctrl", 64'(alu_ctrl), 64'(3'b000));
        chk("midrst_op_count", 64'(op_count), 64'(16'h0));
        #1;
        rst       = 1'b0;
        exp_cnt   = '0;
        last_a    = '0;
        last_b    = '0;
        last_ctrl = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("postrst_no_rsp", 64'(rsp_valid), 64'(1'b0));
        end
        // sub 3-5: borrow and negative
        run_op(32'd3, 32'd5, SUB, 32'hFFFF_FFFE, 32'h0, 5'b01010,
               32'hFFFF_FFFE, 32'h0, 5'b01010, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
